uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream side of the FIFO-fed UART transmitter: the write handshake plus
// the serial line and status outputs.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8
) ();
    logic                         valid_i;
    logic [7:0]                   data_i;
    logic                         ready_o;
    logic                         tx_o;
    logic                         busy_o;
    logic [$clog2(DEPTH+1)-1:0]   level_o;

    modport master (
        output valid_i, data_i,
        input  ready_o, tx_o, busy_o, level_o
    );

    modport slave (
        input  valid_i, data_i,
        output ready_o, tx_o, busy_o, level_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small synchronous FIFO; frames are sent
// back to back while bytes are queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200,
    parameter int DEPTH    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    uart_tx_fifo_if.slave bus
);
    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    generate
        if (CPB < 2) begin : g_cpb_check
            $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             tx, tx_n;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [LVL_W-1:0] level;
    logic             push, pop, empty, ready;

    // A push is judged against the registered level only, so a pop on a full
    // FIFO never frees a slot in the same cycle.
    assign ready = (level != LVL_FULL);
    assign empty = (level == '0);
    assign push  = bus.valid_i && ready;

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem[wptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

    // tx is produced as a next-state value so the line is driven straight from
    // a flop; the shift register moves right so bit 1 is always next in line.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = mem[rptr];
                    tx_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = START;
                end else begin
                    tx_n = 1'b1;
                end
            end
            START: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = mem[rptr];
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign bus.ready_o = ready;
    assign bus.tx_o    = tx;
    assign bus.busy_o  = (state != IDLE) || !empty;
    assign bus.level_o = level;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed frame sequences,
// randomized traffic against a queue-based model, and a loopback receiver.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 6_250_000;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int LVL_W    = $clog2(DEPTH + 1);
    localparam int FRAME    = 10 * CPB;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: queued bytes plus the position inside the frame on air.
    logic [7:0] mq[$];
    bit         m_active;
    int         m_pos;
    logic [7:0] m_cur;
    bit         m_pushed;
    logic [7:0] pop_log[$];

    logic [7:0] rx_q[$];
    int         rx_frame_err = 0;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic [2:0] exp_level;
        logic       exp_busy;
        logic       exp_tx;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit do_pop;
        bit do_push;
        if (rst_n !== 1'b1) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_pushed = 1'b0;
            return;
        end
        do_pop   = (mq.size() > 0) && (!m_active || m_pos == FRAME - 1);
        do_push  = (bus.valid_i === 1'b1) && (mq.size() < DEPTH);
        m_pushed = do_push;
        if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 1'b0;
        end
        if (do_pop) begin
            m_cur    = mq.pop_front();
            pop_log.push_back(m_cur);
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (do_push) mq.push_back(bus.data_i);
    endtask

    function automatic logic model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[3'(b - 1)];
    endfunction

    task automatic step();
        logic [LVL_W+2:0] act;
        logic [LVL_W+2:0] exp;
        @(posedge clk);
        model_edge();
        #1;
        act = {bus.ready_o, bus.busy_o, bus.tx_o, bus.level_o};
        exp = {logic'(mq.size() != DEPTH), logic'(m_active || mq.size() != 0),
               model_tx(), LVL_W'(mq.size())};
        check_output("lockstep", 32'(act), 32'(exp));
    endtask

    task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] d);
        rst_n       = r;
        bus.valid_i = v;
        bus.data_i  = d;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy_o !== 1'b0 && n < budget) begin
            apply_stimulus(1'b1, 1'b0, 8'h00);
            n++;
        end
        check_output("drain_done", 32'(bus.busy_o), 32'd0);
        repeat (4) apply_stimulus(1'b1, 1'b0, 8'h00);
    endtask

    task automatic fresh_start();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        rx_q.delete();
        pop_log.delete();
    endtask

    task automatic compare_rx(input string name, input logic [7:0] exp[$]);
        check_output({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
        for (int i = 0; i < rx_q.size() && i < exp.size(); i++) begin
            check_output(name, 32'(rx_q[i]), 32'(exp[i]));
        end
    endtask

    // Loopback receiver: finds the start edge, samples mid-bit.
    initial begin : rx_proc
        int         cnt;
        bit         rx_busy;
        logic [7:0] sh;
        cnt     = 0;
        rx_busy = 1'b0;
        sh      = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (bus.tx_o === 1'b0) begin
                    rx_busy = 1'b1;
                    cnt     = 0;
                end
            end else begin
                cnt++;
                if (cnt == CPB / 2) begin
                    if (bus.tx_o !== 1'b0) rx_busy = 1'b0;
                end else if (cnt == 9 * CPB + CPB / 2) begin
                    if (bus.tx_o !== 1'b1) rx_frame_err++;
                    rx_q.push_back(sh);
                    rx_busy = 1'b0;
                end else if (cnt > CPB / 2 && (cnt - CPB / 2) % CPB == 0) begin
                    sh[3'((cnt - CPB / 2) / CPB - 1)] = bus.tx_o;
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0] exp_bytes[$];
        logic [7:0] pat;
        logic       exp_bit;
        int         n;

        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;

        // Reset with valid high, then fill past full from idle.
        vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b1, 3'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 8'h01, 1'b1, 3'd1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h03, 1'b1, 3'd2, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'h04, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h05, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 8'h06, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0};

        rx_q.delete();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].data);
            check_output("vec_ready", 32'(bus.ready_o), 32'(vecs[i].exp_ready));
            check_output("vec_level", 32'(bus.level_o), 32'(vecs[i].exp_level));
            check_output("vec_busy",  32'(bus.busy_o),  32'(vecs[i].exp_busy));
            check_output("vec_tx",    32'(bus.tx_o),    32'(vecs[i].exp_tx));
        end
        wait_idle(1000);
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        compare_rx("full_order", exp_bytes);

        // Single 0xA5 frame, bit by bit.
        fresh_start();
        pat = 8'hA5;
        apply_stimulus(1'b1, 1'b1, pat);
        for (int i = 0; i < FRAME; i++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00);
            if (i < CPB)           exp_bit = 1'b0;
            else if (i >= 9 * CPB) exp_bit = 1'b1;
            else                   exp_bit = pat[3'(i / CPB - 1)];
            check_output("a5_tx", 32'(bus.tx_o), 32'(exp_bit));
        end
        check_output("a5_busy_e80", 32'(bus.busy_o), 32'd1);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("a5_busy_e81", 32'(bus.busy_o), 32'd0);
        check_output("a5_tx_e81", 32'(bus.tx_o), 32'd1);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        fresh_start();
        apply_stimulus(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 0) apply_stimulus(1'b1, 1'b1, 8'hFF);
            else        apply_stimulus(1'b1, 1'b0, 8'h00);
            n = i % FRAME;
            if (n < CPB)           exp_bit = 1'b0;
            else if (n >= 9 * CPB) exp_bit = 1'b1;
            else                   exp_bit = (i >= FRAME);
            check_output("b2b_tx", 32'(bus.tx_o), 32'(exp_bit));
        end
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("b2b_busy_end", 32'(bus.busy_o), 32'd0);
        exp_bytes = '{8'h00, 8'hFF};
        compare_rx("b2b_rx", exp_bytes);

        // Push on the very edge the FSM pops with level 2.
        fresh_start();
        apply_stimulus(1'b1, 1'b1, 8'h21);
        apply_stimulus(1'b1, 1'b1, 8'h22);
        apply_stimulus(1'b1, 1'b1, 8'h23);
        repeat (FRAME - 2) apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("pushpop_level_before", 32'(bus.level_o), 32'd2);
        apply_stimulus(1'b1, 1'b1, 8'h24);
        check_output("pushpop_level_after", 32'(bus.level_o), 32'd2);
        check_output("pushpop_tx_start", 32'(bus.tx_o), 32'd0);
        wait_idle(1000);
        exp_bytes = '{8'h21, 8'h22, 8'h23, 8'h24};
        compare_rx("pushpop_rx", exp_bytes);

        // Reset at cycle 30 of a 0x3C frame with two bytes queued.
        fresh_start();
        apply_stimulus(1'b1, 1'b1, 8'h3C);
        apply_stimulus(1'b1, 1'b1, 8'h41);
        apply_stimulus(1'b1, 1'b1, 8'h42);
        check_output("midrst_level_pre", 32'(bus.level_o), 32'd2);
        repeat (28) apply_stimulus(1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 8'h55);
        check_output("midrst_tx", 32'(bus.tx_o), 32'd1);
        check_output("midrst_level", 32'(bus.level_o), 32'd0);
        check_output("midrst_busy", 32'(bus.busy_o), 32'd0);
        check_output("midrst_ready", 32'(bus.ready_o), 32'd1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00);
            check_output("midrst_line_high", 32'(bus.tx_o), 32'd1);
        end
        check_output("midrst_rx_none", 32'(rx_q.size()), 32'd0);

        // Randomized traffic: bursty, then sparse.
        fresh_start();
        for (int i = 0; i < 2000; i++) begin
            apply_stimulus(1'b1, logic'($urandom_range(0, 3) == 0), 8'($urandom));
        end
        for (int i = 0; i < 2000; i++) begin
            apply_stimulus(1'b1, logic'($urandom_range(0, 99) == 0), 8'($urandom));
        end
        wait_idle(1000);
        exp_bytes = pop_log;
        compare_rx("rand_rx", exp_bytes);

        // Loopback of 0x00..0xFF.
        fresh_start();
        exp_bytes.delete();
        for (int b = 0; b < 256; b++) begin
            n = 0;
            do begin
                apply_stimulus(1'b1, 1'b1, 8'(b));
                n++;
            end while (!m_pushed && n < 200);
            check_output("seq_accept", 32'(m_pushed), 32'd1);
            exp_bytes.push_back(8'(b));
        end
        bus.valid_i = 1'b0;
        wait_idle(1000);
        compare_rx("seq_rx", exp_bytes);
        check_output("rx_frame_errors", 32'(rx_frame_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
